// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO requester (master) and fifo_ctrl (slave).
// FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty to the bundle.
interface fifo_ctrl_if #(parameter int ADDR_W = 3);
   logic              wr_en;
   logic              rd_en;
   logic              we;
   logic [ADDR_W-1:0] wAddr;
   logic              re;
   logic [ADDR_W-1:0] rAddr;
   logic              full;
   logic              empty;
   logic              wr_ack;
   logic              wr_err;
   logic              rd_ack;
   logic              rd_err;
   logic [ADDR_W:0]   data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic              almost_full;
   logic              almost_empty;

   modport master (output wr_en, rd_en,
                   input  we, wAddr, re, rAddr, full, empty, wr_ack, wr_err,
                          rd_ack, rd_err, data_count, almost_full, almost_empty);
   modport slave  (input  wr_en, rd_en,
                   output we, wAddr, re, rAddr, full, empty, wr_ack, wr_err,
                          rd_ack, rd_err, data_count, almost_full, almost_empty);
`else
   modport master (output wr_en, rd_en,
                   input  we, wAddr, re, rAddr, full, empty, wr_ack, wr_err,
                          rd_ack, rd_err, data_count);
   modport slave  (input  wr_en, rd_en,
                   output we, wAddr, re, rAddr, full, empty, wr_ack, wr_err,
                          rd_ack, rd_err, data_count);
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO control/pointer stage: Moore FSM, strobe/ack one cycle after the sampled request,
// pointer/count update on the following edge; rejects instead of stalling. Option: FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl #(
   parameter int ADDR_W = 3
) (
   input  logic       clk,
   input  logic       reset,
   fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_C = CNT_ONE << ADDR_W;

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      NO_OP    = 3'd1,
      WRITE    = 3'd2,
      WR_ERROR = 3'd3,
      READ     = 3'd4,
      RD_ERROR = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] head_q, head_d;
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic [ADDR_W:0]   count_q, count_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // The current state's update lands at this edge, so the next request is judged on count_d.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      state_d = NO_OP;
      case (state_q)
         WRITE: begin
            tail_d  = tail_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
         end
         READ: begin
            head_d  = head_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
         end
         default: ;
      endcase
      if (state_q != INIT) begin
         if (bus.wr_en && !bus.rd_en) begin
            state_d = (count_d == DEPTH_C) ? WR_ERROR : WRITE;
         end else if (bus.rd_en && !bus.wr_en) begin
            state_d = (count_d == '0) ? RD_ERROR : READ;
         end
      end
   end

   always_comb begin
      bus.we     = 1'b0;
      bus.wr_ack = 1'b0;
      bus.wr_err = 1'b0;
      bus.re     = 1'b0;
      bus.rd_ack = 1'b0;
      bus.rd_err = 1'b0;
      case (state_q)
         WRITE: begin
            bus.we     = 1'b1;
            bus.wr_ack = 1'b1;
         end
         READ: begin
            bus.re     = 1'b1;
            bus.rd_ack = 1'b1;
         end
         WR_ERROR: bus.wr_err = 1'b1;
         RD_ERROR: bus.rd_err = 1'b1;
         default: ;
      endcase
   end

   assign bus.wAddr      = tail_q;
   assign bus.rAddr      = head_q;
   assign bus.data_count = count_q;
   assign bus.full       = (count_q == DEPTH_C);
   assign bus.empty      = (count_q == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
   // Held low while in INIT so both flags read 0 during and just out of reset.
   assign bus.almost_full  = (state_q != INIT) && (count_q >= (DEPTH_C - CNT_ONE));
   assign bus.almost_empty = (state_q != INIT) && (count_q <= CNT_ONE);
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus randomized traffic against a request/outcome model.
module tb_fifo_ctrl;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int VW     = 8 + 2*ADDR_W + ADDR_W + 1;
   localparam int OP_NONE = 0, OP_W = 1, OP_WE = 2, OP_R = 3, OP_RE = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   // Model: outcome granted to the last sampled request, applied at the next edge.
   int m_head, m_tail, m_count, m_op;
   bit m_init;
   logic [ADDR_W-1:0] addr_q[$];

   fifo_ctrl_if #(.ADDR_W(ADDR_W)) bus();
   fifo_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_head = 0; m_tail = 0; m_count = 0; m_op = OP_NONE; m_init = 1'b1;
   endtask

   task automatic model_edge(input bit w, input bit r);
      if (m_op == OP_W) begin
         m_tail = (m_tail + 1) % DEPTH;
         m_count = m_count + 1;
      end else if (m_op == OP_R) begin
         m_head = (m_head + 1) % DEPTH;
         m_count = m_count - 1;
      end
      if (m_init) begin
         m_init = 1'b0;
         m_op = OP_NONE;
      end else if (w && !r) begin
         m_op = (m_count == DEPTH) ? OP_WE : OP_W;
      end else if (r && !w) begin
         m_op = (m_count == 0) ? OP_RE : OP_R;
      end else begin
         m_op = OP_NONE;
      end
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [ADDR_W-1:0] wa, ra;
      logic [ADDR_W:0]   c;
      wa = ADDR_W'(m_tail);
      ra = ADDR_W'(m_head);
      c  = (ADDR_W+1)'(m_count);
      return {m_op == OP_W, m_op == OP_R, m_op == OP_W, m_op == OP_WE, m_op == OP_R, m_op == OP_RE,
              m_count == DEPTH, m_count == 0, wa, ra, c};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.we, bus.re, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err,
              bus.full, bus.empty, bus.wAddr, bus.rAddr, bus.data_count};
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit w, input bit r);
      bus.wr_en = w;
      bus.rd_en = r;
      @(posedge clk);
      model_edge(w, r);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
         n_err++;
         $display("FAIL reset_hold: got %h want %h", dut_vec(), model_vec());
      end
      reset = 1'b0;
      cycle(1'b1, 1'b0);
      n_vec++;
      if (bus.we !== 1'b0 || bus.wr_err !== 1'b0 || bus.data_count !== '0) begin
         n_err++;
         $display("FAIL init_drop: we=%b wr_err=%b count=%0d want 0 0 0", bus.we, bus.wr_err, bus.data_count);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0);
         n_vec++;
         if (bus.empty !== 1'b1 || bus.full !== 1'b0 || dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL idle_%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 1'b0);
         n_vec++;
         if (bus.we !== 1'b1 || bus.wr_ack !== 1'b1 || bus.wAddr !== ADDR_W'(i)) begin
            n_err++;
            $display("FAIL fill_%0d: we=%b ack=%b wAddr=%0d want 1 1 %0d", i, bus.we, bus.wr_ack, bus.wAddr, i);
         end
      end
      cycle(1'b1, 1'b0);
      n_vec++;
      if (bus.wr_err !== 1'b1 || bus.we !== 1'b0 || bus.full !== 1'b1 ||
          bus.data_count !== (ADDR_W+1)'(DEPTH) || bus.wAddr !== '0) begin
         n_err++;
         $display("FAIL write_full: err=%b we=%b full=%b count=%0d wAddr=%0d want 1 0 1 8 0",
                  bus.wr_err, bus.we, bus.full, bus.data_count, bus.wAddr);
      end
      cycle(1'b0, 1'b0);
      n_vec++;
      if (dut_vec() !== model_vec() || bus.data_count !== (ADDR_W+1)'(DEPTH)) begin
         n_err++;
         $display("FAIL full_hold: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1);
         n_vec++;
         if (bus.re !== 1'b1 || bus.rd_ack !== 1'b1 || bus.rAddr !== ADDR_W'(i)) begin
            n_err++;
            $display("FAIL drain_%0d: re=%b ack=%b rAddr=%0d want 1 1 %0d", i, bus.re, bus.rd_ack, bus.rAddr, i);
         end
      end
      cycle(1'b0, 1'b1);
      n_vec++;
      if (bus.rd_err !== 1'b1 || bus.re !== 1'b0 || bus.empty !== 1'b1 || bus.rAddr !== '0) begin
         n_err++;
         $display("FAIL read_empty: err=%b re=%b empty=%b rAddr=%0d want 1 0 1 0",
                  bus.rd_err, bus.re, bus.empty, bus.rAddr);
      end
   endtask

   task automatic test_wrap();
      repeat (5) cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0);
         n_vec++;
         if (bus.we !== 1'b1 || bus.wAddr !== ADDR_W'((5 + i) % DEPTH)) begin
            n_err++;
            $display("FAIL wrap_%0d: we=%b wAddr=%0d want 1 %0d", i, bus.we, bus.wAddr, (5 + i) % DEPTH);
         end
      end
      cycle(1'b0, 1'b0);
      n_vec++;
      if (bus.data_count !== (ADDR_W+1)'(6) || bus.rAddr !== ADDR_W'(5) || dut_vec() !== model_vec()) begin
         n_err++;
         $display("FAIL wrap_end: count=%0d rAddr=%0d want 6 5", bus.data_count, bus.rAddr);
      end
   endtask

   task automatic test_both_and_reset();
      repeat (3) cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      n_vec++;
      if (bus.we !== 1'b0 || bus.re !== 1'b0 || bus.wr_err !== 1'b0 || bus.rd_err !== 1'b0 ||
          bus.data_count !== (ADDR_W+1)'(3)) begin
         n_err++;
         $display("FAIL both_req: we=%b re=%b count=%0d want 0 0 3", bus.we, bus.re, bus.data_count);
      end
      cycle(1'b1, 1'b0);
      reset = 1'b1;
      #1;
      n_vec++;
      if (bus.we !== 1'b0 || bus.empty !== 1'b1 || bus.data_count !== '0 ||
          bus.wAddr !== '0 || bus.rAddr !== '0) begin
         n_err++;
         $display("FAIL reset_mid_write: we=%b empty=%b count=%0d wAddr=%0d rAddr=%0d want 0 1 0 0 0",
                  bus.we, bus.empty, bus.data_count, bus.wAddr, bus.rAddr);
      end
      model_reset();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b0, 1'b0);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
         n_err++;
         $display("FAIL after_reset: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_random();
      int wp, rp;
      bit w, r;
      logic [ADDR_W-1:0] exp_a;
      addr_q.delete();
      for (int i = 0; i < 600; i++) begin
         wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
         rp = 100 - wp;
         w = ($urandom_range(0, 99) < wp);
         r = ($urandom_range(0, 99) < rp);
         cycle(w, r);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL rand_%0d: got %h want %h (w=%b r=%b)", i, dut_vec(), model_vec(), w, r);
         end
         if (bus.we === 1'b1) addr_q.push_back(bus.wAddr);
         if (bus.re === 1'b1) begin
            n_vec++;
            if (addr_q.size() == 0) begin
               n_err++;
               $display("FAIL rand_order_%0d: read of rAddr=%0d with nothing written", i, bus.rAddr);
            end else begin
               exp_a = addr_q.pop_front();
               if (bus.rAddr !== exp_a) begin
                  n_err++;
                  $display("FAIL rand_order_%0d: rAddr=%0d want %0d", i, bus.rAddr, exp_a);
               end
            end
         end
      end
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_both_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
